// File: rtl/vga_timing_gen_if.sv
// Pixel-side bundle of the VGA timing generator: colour source in, raster
// coordinates, strobes and pin-aligned video out.
interface vga_timing_gen_if #(
    parameter int COLOUR_W = 12,
    parameter int HW       = 11,
    parameter int VW       = 10
);
    logic [COLOUR_W-1:0] colour_in;
    logic [HW-1:0]       x;
    logic [VW-1:0]       y;
    logic                pix_req;
    logic [COLOUR_W-1:0] colour_out;
    logic                de;
    logic                HS;
    logic                VS;
    logic                line_trig;
    logic                frame_trig;

    modport master (
        input  colour_in,
        output x, y, pix_req, colour_out, de, HS, VS, line_trig, frame_trig
    );

    modport slave (
        output colour_in,
        input  x, y, pix_req, colour_out, de, HS, VS, line_trig, frame_trig
    );
endinterface

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a LAT-deep alignment pipe so
// that de/HS/VS leave the block on the same edge as the matching colour.
module vga_timing_gen #(
    parameter int H_VISIBLE  = 800,
    parameter int H_FRONT    = 56,
    parameter int H_SYNC     = 120,
    parameter int H_BACK     = 64,
    parameter int V_VISIBLE  = 600,
    parameter int V_FRONT    = 37,
    parameter int V_SYNC     = 6,
    parameter int V_BACK     = 23,
    parameter int H_SYNC_POL = 1,
    parameter int V_SYNC_POL = 1,
    parameter int CLK_DIV    = 2,
    parameter int LAT        = 1,
    parameter int COLOUR_W   = 12,
    parameter int HW         = 11,
    parameter int VW         = 10
) (
    input  logic              clk,
    input  logic              rst,
    vga_timing_gen_if.master  bus
);
    localparam int H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_START = H_VISIBLE + H_FRONT;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_VISIBLE + V_FRONT;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam logic HS_ON  = H_SYNC_POL[0];
    localparam logic VS_ON  = V_SYNC_POL[0];

    logic [3:0]    div_reg, div_next;
    logic [HW-1:0] h_reg, h_next;
    logic [VW-1:0] v_reg, v_next;
    logic          pix_en, h_last, v_last;
    logic          vis, hs_act, vs_act;
    logic          line_trig;

    // With CLK_DIV=1 the divider never leaves 0, so pix_en stays high.
    assign pix_en = (div_reg == 4'(CLK_DIV - 1));
    assign h_last = (h_reg == HW'(H_TOTAL - 1));
    assign v_last = (v_reg == VW'(V_TOTAL - 1));

    always_comb begin
        div_next = pix_en ? 4'd0 : div_reg + 4'd1;
        h_next   = h_reg;
        v_next   = v_reg;
        if (pix_en) begin
            h_next = h_last ? '0 : h_reg + 1'b1;
            if (h_last) begin
                v_next = v_last ? '0 : v_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_reg <= 4'd0;
            h_reg   <= '0;
            v_reg   <= '0;
        end else begin
            div_reg <= div_next;
            h_reg   <= h_next;
            v_reg   <= v_next;
        end
    end

    assign vis    = (h_reg < HW'(H_VISIBLE)) && (v_reg < VW'(V_VISIBLE));
    assign hs_act = (h_reg >= HW'(HS_START)) && (h_reg < HW'(HS_END));
    assign vs_act = (v_reg >= VW'(VS_START)) && (v_reg < VW'(VS_END));

    assign bus.x       = vis ? h_reg : '0;
    assign bus.y       = vis ? v_reg : '0;
    assign bus.pix_req = vis;

    // Strobes come straight off the counters so swap logic sees them early.
    assign line_trig      = pix_en && h_last;
    assign bus.line_trig  = line_trig;
    assign bus.frame_trig = line_trig && v_last;

    // Bit 2 = vis, bit 1 = hs_act, bit 0 = vs_act; element k is k clks old.
    logic [2:0] stage_d [LAT+1];
    assign stage_d[0] = {vis, hs_act, vs_act};

    genvar gi;
    generate
        for (gi = 0; gi < LAT; gi++) begin : g_stage
            logic [2:0] stage_reg;
            always_ff @(posedge clk) begin
                if (rst) begin
                    stage_reg <= 3'b000;
                end else begin
                    stage_reg <= stage_d[gi];
                end
            end
            assign stage_d[gi+1] = stage_reg;
        end
    endgenerate

    logic [2:0] tap;
    assign tap = stage_d[LAT];

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.colour_out <= '0;
            bus.de         <= 1'b0;
            bus.HS         <= ~HS_ON;
            bus.VS         <= ~VS_ON;
        end else begin
            bus.colour_out <= tap[2] ? bus.colour_in : '0;
            bus.de         <= tap[2];
            bus.HS         <= tap[1] ? HS_ON : ~HS_ON;
            bus.VS         <= tap[0] ? VS_ON : ~VS_ON;
        end
    end
endmodule

// File: doc/vga_timing_gen.md
# vga_timing_gen

Parametrised VGA raster timing generator and output aligner. It replaces the fixed-mode 800x600 driver. The block sits between the system clock domain and the VGA pins, and feeds pixel coordinates to the frame buffer or pixel source. It adds configurable porch and sync timing, sync polarity, pixel clock divide ratio, colour width, and colour-source pipeline latency. It also adds line and frame strobes, a pixel-request qualifier and a delayed data-enable output.

## Interface
Parameters:
- H_VISIBLE, 800: active pixels per line
- H_FRONT, 56: horizontal front porch, in pixels
- H_SYNC, 120: horizontal sync width, in pixels
- H_BACK, 64: horizontal back porch, in pixels
- V_VISIBLE, 600: active lines per frame
- V_FRONT, 37: vertical front porch, in lines
- V_SYNC, 6: vertical sync width, in lines
- V_BACK, 23: vertical back porch, in lines
- H_SYNC_POL, 1: HS active level (1 = active high)
- V_SYNC_POL, 1: VS active level (1 = active high)
- CLK_DIV, 2: clk cycles per pixel; range 1..16
- LAT, 1: clk cycles from x/y presentation to colour_in valid; range 0..7
- COLOUR_W, 12: colour bus width
- HW, 11: horizontal counter and x width
- VW, 10: vertical counter and y width

Ports:
- clk, in, 1: system clock
- rst, in, 1: synchronous reset, active high
- colour_in, in, COLOUR_W: pixel colour from the source, valid LAT cycles after x/y
- x, out, HW: current pixel column; 0 outside the visible area
- y, out, VW: current pixel row; 0 outside the visible area
- pix_req, out, 1: current x/y lies in the visible area
- colour_out, out, COLOUR_W: registered colour to the pins; 0 when blanked
- de, out, 1: data enable, aligned with colour_out
- HS, out, 1: horizontal sync, aligned with colour_out
- VS, out, 1: vertical sync, aligned with colour_out
- line_trig, out, 1: one-clk pulse on the last pixel tick of each line
- frame_trig, out, 1: one-clk pulse on the last pixel tick of each frame

## Operation
- Totals: H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK; V_TOTAL likewise. Both must fit in HW and VW bits respectively.
- Divider: div counts 0..CLK_DIV-1 and wraps. pix_en = (div == CLK_DIV-1). For CLK_DIV=1, pix_en is constantly 1.
- Horizontal counter h: on pix_en, h increments. It wraps from H_TOTAL-1 to 0.
- Vertical counter v: on pix_en with h == H_TOTAL-1, v increments. It wraps from V_TOTAL-1 to 0.
- Visible area: vis = (h < H_VISIBLE) && (v < V_VISIBLE).
- Combinational outputs: x = vis ? h : 0; y = vis ? v : 0; pix_req = vis. Each x/y value holds for CLK_DIV clks.
- Sync windows: hs_act = H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC. vs_act uses the same form on v with the V parameters.
- Sync pin levels: pin = act ? POL : ~POL.
- Stage-0 signals are vis, hs_act and vs_act. Each passes through a LAT-deep clk-rate shift register.
- Final output register: colour_out <= vis_d[LAT] ? colour_in : 0. de, HS and VS are registered from their delayed counterparts at the same edge.
- line_trig = pix_en && h == H_TOTAL-1.
- frame_trig = line_trig && v == V_TOTAL-1.
- line_trig and frame_trig are combinational from the counter registers and are not delayed. They are intended for the frame-buffer swap logic.
- Counter-width arithmetic is unsigned. No saturation is needed because the wrap points are exact.

## Timing
- Reset values after the rst edge: div=0, h=0, v=0, every delay stage cleared.
  - colour_out=0 and de=0.
  - HS=~H_SYNC_POL and VS=~V_SYNC_POL.
  - line_trig=0 and frame_trig=0.
- x/y/pix_req reflect (0,0) in the first cycle after reset, as a direct consequence of h=v=0.
- rst asserted mid-frame returns the block to the reset state on the next edge. No partial line is emitted afterward.
- Latency: if x/y is presented in cycle n, the source supplies colour_in in cycle n+LAT. colour_out, de, HS and VS for that pixel appear in cycle n+LAT+1.
- HS/VS/de edges are aligned with the colour_out edges for every LAT value.
- First pix_en after reset occurs CLK_DIV-1 cycles after reset deasserts, i.e. h becomes 1 at cycle CLK_DIV.
- Simultaneous wraps: when h and v wrap in the same clk, line_trig and frame_trig both pulse in that clk.

## Test plan
- Reset check, defaults: hold rst for 3 clks, release. Required: colour_out=0, HS=VS=0, de=0 until the first visible pixel exits the pipe. de rises at clk 2.
- Default line and frame period (CLK_DIV=2): line_trig period = 1040*2 = 2080 clks. frame_trig period = 1040*666*2 = 1,385,280 clks. HS is high for exactly 240 clks per line, starting 1712 clks after x=0 enters. VS is high for 6 lines.
- Latency: LAT=3, colour_in = x[11:0] driven 3 clks late. Required: colour_out == pixel index in cycle n+4. colour_out is 0 and de=0 from x=800 through the end of the line.
- Small mode for fast simulation: H 8/2/2/2, V 4/1/1/1, CLK_DIV=1, H_SYNC_POL=0. Required: HS low at h=10,11 only. Frame = 14*7 = 98 clks. frame_trig coincides with line_trig every 7th line.
- Mid-frame reset: assert rst at h=500, v=300 for 1 clk. Required: the next cycle shows x=y=0, pix_req=1. colour_out=0 and HS/VS are inactive until the pipe refills.
- Sweep: LAT=0 and LAT=7 with CLK_DIV=1 and CLK_DIV=16. Required: alignment between de, HS, VS and colour_out is unchanged.
